// File: rtl/mux2_arbiter_pkg.sv
// ============================================================================
//  Module   : mux2_arbiter_pkg
//  Brief    : Shared types and constants for the two-requester mux arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux2_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t GNT_A = 2'd1;
    localparam state_t GNT_B = 2'd2;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    localparam int DEFAULT_DW        = 8;
    localparam int DEFAULT_MAX_BURST = 4;

endpackage

`default_nettype wire

// File: rtl/mux2_arbiter_if.sv
// ============================================================================
//  Module   : mux2_arbiter_if
//  Brief    : Requester, consumer and status signals of mux2_arbiter.
//             MUX2_ARBITER_STATS_EN adds the burst counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux2_arbiter_if
    import mux2_arbiter_pkg::*;
#(
    parameter int DW = DEFAULT_DW
);
    logic          req_a;
    logic [DW-1:0] data_a;
    logic          last_a;
    logic          gnt_a;
    logic          req_b;
    logic [DW-1:0] data_b;
    logic          last_b;
    logic          gnt_b;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          sel;
    logic          busy;
`ifdef MUX2_ARBITER_STATS_EN
    logic [7:0]    burst_cnt_a;
    logic [7:0]    burst_cnt_b;
`endif

    // Arbiter side
    modport slave (
        input  req_a, data_a, last_a, req_b, data_b, last_b, out_ready,
        output gnt_a, gnt_b, out_valid, out_data, sel, busy
`ifdef MUX2_ARBITER_STATS_EN
        , output burst_cnt_a, burst_cnt_b
`endif
    );

    // Requesters plus consumer side
    modport master (
        output req_a, data_a, last_a, req_b, data_b, last_b, out_ready,
        input  gnt_a, gnt_b, out_valid, out_data, sel, busy
`ifdef MUX2_ARBITER_STATS_EN
        , input burst_cnt_a, burst_cnt_b
`endif
    );

endinterface

`default_nettype wire

// File: rtl/mux2_rr_pick.sv
// ============================================================================
//  Module   : mux2_rr_pick
//  Brief    : Round-robin choice between two requesters while the arbiter idles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_rr_pick
    import mux2_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic rr_last,
    output logic pick,
    output logic pick_valid
);

    always_comb begin
        pick_valid = req_a | req_b;
        if (req_a && req_b) begin
            pick = (rr_last == SIDE_A) ? SIDE_B : SIDE_A;
        end else if (req_b) begin
            pick = SIDE_B;
        end else begin
            pick = SIDE_A;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux2_arbiter.sv
// ============================================================================
//  Module   : mux2_arbiter
//  Brief    : Round-robin, burst-locked 2:1 mux arbiter with registered output
//             stage. Define MUX2_ARBITER_STATS_EN for per-side burst counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int BC_W      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux2_arbiter_if.slave  bus
);

    localparam logic [BC_W-1:0] c_last_beat = BC_W'(MAX_BURST - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sel;
    logic            r_rr_last;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic [BC_W-1:0] r_beat_cnt;

    logic            w_pick;
    logic            w_pick_valid;
    logic            w_enter;
    logic            w_can_accept;
    logic            w_gnt_a;
    logic            w_gnt_b;
    logic            w_busy;
    logic            w_req_cur;
    logic [DW-1:0]   w_data_cur;
    logic            w_last_cur;
    logic            w_side_cur;
    logic            w_xfer;
    logic            w_release;

    mux2_rr_pick u_pick (
        .req_a      (bus.req_a),
        .req_b      (bus.req_b),
        .rr_last    (r_rr_last),
        .pick       (w_pick),
        .pick_valid (w_pick_valid)
    );

    // Fields of whichever side currently owns the datapath
    always_comb begin
        w_req_cur  = 1'b0;
        w_data_cur = '0;
        w_last_cur = 1'b0;
        w_side_cur = SIDE_A;
        case (r_state)
            GNT_A: begin
                w_req_cur  = bus.req_a;
                w_data_cur = bus.data_a;
                w_last_cur = bus.last_a;
                w_side_cur = SIDE_A;
            end
            GNT_B: begin
                w_req_cur  = bus.req_b;
                w_data_cur = bus.data_b;
                w_last_cur = bus.last_b;
                w_side_cur = SIDE_B;
            end
            default: ;
        endcase
    end

    assign w_can_accept = !r_out_valid || bus.out_ready;
    assign w_enter      = (r_state == IDLE) && w_pick_valid;
    assign w_xfer       = w_req_cur && (w_gnt_a || w_gnt_b);
    assign w_release    = (r_state != IDLE) &&
                          (!w_req_cur || (w_xfer && (w_last_cur || (r_beat_cnt == c_last_beat))));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a released side always passes through IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = (w_pick == SIDE_B) ? GNT_B : GNT_A;
                end
            end
            GNT_A, GNT_B: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: grants depend only on registered state and output space
    always_comb begin
        w_gnt_a = (r_state == GNT_A) && w_can_accept;
        w_gnt_b = (r_state == GNT_B) && w_can_accept;
        w_busy  = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= SIDE_A;
            r_rr_last   <= SIDE_B;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_enter) begin
                r_sel      <= w_pick;
                r_beat_cnt <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + BC_W'(1);
            end

            if (w_xfer) begin
                r_out_data  <= w_data_cur;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_release) begin
                r_rr_last <= w_side_cur;
            end
        end
    end

`ifdef MUX2_ARBITER_STATS_EN
    logic [7:0] r_burst_cnt_a;
    logic [7:0] r_burst_cnt_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt_a <= 8'd0;
            r_burst_cnt_b <= 8'd0;
        end else if (w_enter) begin
            if (w_pick == SIDE_A && r_burst_cnt_a != 8'hFF) begin
                r_burst_cnt_a <= r_burst_cnt_a + 8'd1;
            end
            if (w_pick == SIDE_B && r_burst_cnt_b != 8'hFF) begin
                r_burst_cnt_b <= r_burst_cnt_b + 8'd1;
            end
        end
    end

    assign bus.burst_cnt_a = r_burst_cnt_a;
    assign bus.burst_cnt_b = r_burst_cnt_b;
`endif

    assign bus.gnt_a     = w_gnt_a;
    assign bus.gnt_b     = w_gnt_b;
    assign bus.busy      = w_busy;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_mux2_arbiter.sv
// ============================================================================
//  Module   : tb_mux2_arbiter
//  Brief    : Directed self-checking bench for mux2_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux2_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mux2_arbiter_if #(.DW(8)) bif ();

    mux2_arbiter #(.DW(8), .MAX_BURST(4), .BC_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bif.req_a     = 1'b0;
        bif.data_a    = 8'h00;
        bif.last_a    = 1'b0;
        bif.req_b     = 1'b0;
        bif.data_b    = 8'h00;
        bif.last_b    = 1'b0;
        bif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_out_valid", bif.out_valid, 0);
        chk("rst_out_data",  bif.out_data,  0);
        chk("rst_sel",       bif.sel,       0);
        chk("rst_busy",      bif.busy,      0);
        chk("rst_gnt_a",     bif.gnt_a,     0);
        chk("rst_gnt_b",     bif.gnt_b,     0);

        // Single requester A: 3-beat burst
        bif.req_a  = 1'b1;
        bif.data_a = 8'h11;
        #1;
        chk("s1_idle_gnt_a", bif.gnt_a, 0);
        tick();
        chk("s1_gnt_a",  bif.gnt_a, 1);
        chk("s1_busy",   bif.busy,  1);
        chk("s1_sel",    bif.sel,   0);
        chk("s1_ov0",    bif.out_valid, 0);
        tick();
        chk("s1_d11",    bif.out_data,  8'h11);
        chk("s1_ov1",    bif.out_valid, 1);
        bif.data_a = 8'h22;
        tick();
        chk("s1_d22",    bif.out_data, 8'h22);
        chk("s1_gnt_b",  bif.gnt_b,    0);
        bif.data_a = 8'h33;
        bif.last_a = 1'b1;
        tick();
        chk("s1_d33",    bif.out_data, 8'h33);
        chk("s1_rel",    bif.busy,     0);
        chk("s1_rel_g",  bif.gnt_a,    0);
        chk("s1_sel_h",  bif.sel,      0);
        bif.req_a  = 1'b0;
        bif.last_a = 1'b0;
        tick();
        chk("s1_drain",  bif.out_valid, 0);

        // Tie round-robin with single-beat bursts
        do_reset();
        bif.req_a  = 1'b1;
        bif.req_b  = 1'b1;
        bif.last_a = 1'b1;
        bif.last_b = 1'b1;
        bif.data_a = 8'hA0;
        bif.data_b = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s2_gnt_a", bif.gnt_a, (i % 2 == 0) ? 1 : 0);
            chk("s2_gnt_b", bif.gnt_b, (i % 2 == 1) ? 1 : 0);
            chk("s2_sel",   bif.sel,   (i % 2 == 1) ? 1 : 0);
            chk("s2_ov0",   bif.out_valid, 0);
            tick();
            chk("s2_data",  bif.out_data, (i % 2 == 1) ? 8'hB0 : 8'hA0);
            chk("s2_ov1",   bif.out_valid, 1);
            chk("s2_idle",  bif.busy, 0);
        end
        bif.req_a  = 1'b0;
        bif.req_b  = 1'b0;
        bif.last_a = 1'b0;
        bif.last_b = 1'b0;
        tick();

        // Burst cap: B limited to 4 beats while A waits
        bif.req_b  = 1'b1;
        bif.data_b = 8'h10;
        tick();
        chk("s3_gnt_b", bif.gnt_b, 1);
        chk("s3_sel_b", bif.sel,   1);
        bif.req_a  = 1'b1;
        bif.last_a = 1'b1;
        bif.data_a = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s3_beat", bif.out_data, 8'h10 + i);
            chk("s3_busy", bif.busy, (i < 3) ? 1 : 0);
            chk("s3_nogA", bif.gnt_a, 0);
            bif.data_b = 8'h11 + 8'(i);
        end
        tick();
        chk("s3_gnt_a2", bif.gnt_a, 1);
        chk("s3_gnt_b2", bif.gnt_b, 0);
        chk("s3_sel_a",  bif.sel,   0);
        tick();
        chk("s3_dAA",    bif.out_data, 8'hAA);
        bif.req_a  = 1'b0;
        bif.last_a = 1'b0;
        tick();
        chk("s3_resume", bif.gnt_b, 1);
        chk("s3_sel_b2", bif.sel,   1);
        tick();
        chk("s3_d14",    bif.out_data, 8'h14);

        // Back-pressure mid-burst
        bif.data_b    = 8'h15;
        bif.out_ready = 1'b0;
        #1;
        chk("s4_stall_g", bif.gnt_b, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_hold_v", bif.out_valid, 1);
            chk("s4_hold_d", bif.out_data,  8'h14);
            chk("s4_hold_g", bif.gnt_b,     0);
        end
        bif.out_ready = 1'b1;
        #1;
        chk("s4_go_g", bif.gnt_b, 1);
        tick();
        chk("s4_d15", bif.out_data, 8'h15);
        bif.data_b = 8'h16;
        bif.last_b = 1'b1;
        tick();
        chk("s4_d16", bif.out_data, 8'h16);
        chk("s4_rel", bif.busy,     0);
        bif.req_b  = 1'b0;
        bif.last_b = 1'b0;
        tick();
        chk("s4_drain", bif.out_valid, 0);

        // Asynchronous reset mid-burst
        bif.req_b  = 1'b1;
        bif.data_b = 8'h55;
        tick();
        tick();
        chk("s5_ov",   bif.out_valid, 1);
        chk("s5_d55",  bif.out_data,  8'h55);
        chk("s5_sel",  bif.sel,       1);
        chk("s5_busy", bif.busy,      1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_ar_ov",   bif.out_valid, 0);
        chk("s5_ar_data", bif.out_data,  0);
        chk("s5_ar_sel",  bif.sel,       0);
        chk("s5_ar_busy", bif.busy,      0);
        chk("s5_ar_gnt",  bif.gnt_b,     0);
        bif.req_a  = 1'b1;
        bif.data_a = 8'h66;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("s5_tie_a", bif.gnt_a, 1);
        chk("s5_tie_b", bif.gnt_b, 0);
        bif.req_a = 1'b0;
        tick();
        chk("s5_drop_busy", bif.busy,      0);
        chk("s5_drop_ov",   bif.out_valid, 0);
        tick();
        chk("s5_next_b",   bif.gnt_b, 1);
        chk("s5_next_sel", bif.sel,   1);
        bif.req_b = 1'b0;
        tick();

`ifdef MUX2_ARBITER_STATS_EN
        // Burst counters saturate at 255
        do_reset();
        chk("st_rst_a", bif.burst_cnt_a, 0);
        chk("st_rst_b", bif.burst_cnt_b, 0);
        bif.req_a  = 1'b1;
        bif.last_a = 1'b1;
        repeat (20) tick();
        chk("st_ten_a", bif.burst_cnt_a, 10);
        repeat (580) tick();
        chk("st_sat_a", bif.burst_cnt_a, 255);
        chk("st_zero_b", bif.burst_cnt_b, 0);
        bif.req_a  = 1'b0;
        bif.last_a = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
